// File: rtl/onboard_top.sv
// Board-level JTAG TAP on the JB header: IDCODE readout, switch sampling and a JTAG-writable LED register.
// Optional: define ONBOARD_TOP_STATE_LED_EN to show the live TAP state code on LED[15:12].
module onboard_top #(
    parameter logic [31:0] IDCODE_VALUE = 32'h1234_5093,
    parameter int          IR_WIDTH     = 4
) (
    input  logic        JB_TCK,
    input  logic        JB_TRST,
    input  logic        JB_TMS,
    input  logic        JB_TDI,
    output logic        JB_TDO,
    input  logic [15:0] SW,
    output logic [15:0] LED
);

    typedef enum logic [3:0] {
        TLR    = 4'hF, RTI    = 4'hC,
        SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR  = 4'h2, EX1_DR = 4'h1,
        PAU_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
        SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR  = 4'hA, EX1_IR = 4'h9,
        PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
    } tap_state_t;

    localparam logic [IR_WIDTH-1:0] OP_IDCODE    = IR_WIDTH'(4'b0100);
    localparam logic [IR_WIDTH-1:0] OP_SAMPLE_SW = IR_WIDTH'(4'b0001);
    localparam logic [IR_WIDTH-1:0] OP_WRITE_LED = IR_WIDTH'(4'b0010);

    tap_state_t          state, state_nxt;
    logic [IR_WIDTH-1:0] ir, ir_sr;
    logic [31:0]         dr_sr;
    logic [15:0]         led_reg;
    logic                tdo_nxt;

    always_ff @(posedge JB_TCK or negedge JB_TRST) begin
        if (!JB_TRST) state <= TLR;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TLR:    state_nxt = JB_TMS ? TLR    : RTI;
            RTI:    state_nxt = JB_TMS ? SEL_DR : RTI;
            SEL_DR: state_nxt = JB_TMS ? SEL_IR : CAP_DR;
            CAP_DR: state_nxt = JB_TMS ? EX1_DR : SH_DR;
            SH_DR:  state_nxt = JB_TMS ? EX1_DR : SH_DR;
            EX1_DR: state_nxt = JB_TMS ? UPD_DR : PAU_DR;
            PAU_DR: state_nxt = JB_TMS ? EX2_DR : PAU_DR;
            EX2_DR: state_nxt = JB_TMS ? UPD_DR : SH_DR;
            UPD_DR: state_nxt = JB_TMS ? SEL_DR : RTI;
            SEL_IR: state_nxt = JB_TMS ? TLR    : CAP_IR;
            CAP_IR: state_nxt = JB_TMS ? EX1_IR : SH_IR;
            SH_IR:  state_nxt = JB_TMS ? EX1_IR : SH_IR;
            EX1_IR: state_nxt = JB_TMS ? UPD_IR : PAU_IR;
            PAU_IR: state_nxt = JB_TMS ? EX2_IR : PAU_IR;
            EX2_IR: state_nxt = JB_TMS ? UPD_IR : SH_IR;
            UPD_IR: state_nxt = JB_TMS ? SEL_DR : RTI;
            default: state_nxt = TLR;
        endcase
    end

    // IR shift register and instruction register
    always_ff @(posedge JB_TCK or negedge JB_TRST) begin
        if (!JB_TRST) begin
            ir_sr <= '0;
            ir    <= OP_IDCODE;
        end else begin
            if (state == CAP_IR)     ir_sr <= IR_WIDTH'(1);
            else if (state == SH_IR) ir_sr <= {JB_TDI, ir_sr[IR_WIDTH-1:1]};
            if (state == TLR)         ir <= OP_IDCODE;
            else if (state == UPD_IR) ir <= ir_sr;
        end
    end

    // One physical DR shift register; the active length follows the instruction
    // so TDI always enters at the MSB of the selected register.
    always_ff @(posedge JB_TCK or negedge JB_TRST) begin
        if (!JB_TRST) begin
            dr_sr <= '0;
        end else if (state == CAP_DR) begin
            case (ir)
                OP_IDCODE:    dr_sr <= IDCODE_VALUE;
                OP_SAMPLE_SW: dr_sr <= {16'h0000, SW};
                OP_WRITE_LED: dr_sr <= {16'h0000, led_reg};
                default:      dr_sr <= '0;
            endcase
        end else if (state == SH_DR) begin
            case (ir)
                OP_IDCODE:    dr_sr <= {JB_TDI, dr_sr[31:1]};
                OP_SAMPLE_SW,
                OP_WRITE_LED: dr_sr <= {16'h0000, JB_TDI, dr_sr[15:1]};
                default:      dr_sr <= {31'h0, JB_TDI};
            endcase
        end
    end

    always_ff @(posedge JB_TCK or negedge JB_TRST) begin
        if (!JB_TRST)                                   led_reg <= '0;
        else if (state == UPD_DR && ir == OP_WRITE_LED) led_reg <= dr_sr[15:0];
    end

    always_comb begin
        tdo_nxt = 1'b0;
        if (state == SH_DR)      tdo_nxt = dr_sr[0];
        else if (state == SH_IR) tdo_nxt = ir_sr[0];
    end

    // TDO launches on the falling edge so the probe samples it cleanly on the next rise
    always_ff @(negedge JB_TCK or negedge JB_TRST) begin
        if (!JB_TRST) JB_TDO <= 1'b0;
        else          JB_TDO <= tdo_nxt;
    end

`ifdef ONBOARD_TOP_STATE_LED_EN
    assign LED = {state, led_reg[11:0]};
`else
    assign LED = led_reg;
`endif

endmodule

// File: tb/tb_onboard_top.sv
// Scoreboard bench for onboard_top: directed JTAG scans push expected TDO/LED values, a monitor compares.
module tb_onboard_top;

    localparam logic [31:0] ID = 32'h1234_5093;

    logic        JB_TCK, JB_TRST, JB_TMS, JB_TDI, JB_TDO;
    logic [15:0] SW, LED;

    onboard_top #(.IDCODE_VALUE(ID), .IR_WIDTH(4)) dut (
        .JB_TCK(JB_TCK), .JB_TRST(JB_TRST), .JB_TMS(JB_TMS), .JB_TDI(JB_TDI),
        .JB_TDO(JB_TDO), .SW(SW), .LED(LED)
    );

    typedef struct {
        bit          is_led;
        logic [15:0] exp;
        string       name;
    } chk_t;

    chk_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

`ifdef ONBOARD_TOP_STATE_LED_EN
    localparam logic [15:0] LED_MASK = 16'h0FFF;
`else
    localparam logic [15:0] LED_MASK = 16'hFFFF;
`endif

    initial begin
        JB_TCK = 1'b0;
        forever #5 JB_TCK = ~JB_TCK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Monitor: TDO/LED are stable 2ns after the falling edge until the next rising edge
    initial begin
        chk_t        c;
        logic [15:0] act;
        forever begin
            @(negedge JB_TCK);
            #2;
            while (q.size() > 0) begin
                c   = q.pop_front();
                act = c.is_led ? (LED & LED_MASK) : {15'h0, JB_TDO};
                n_cmp++;
                if (act !== (c.exp & (c.is_led ? LED_MASK : 16'h0001))) begin
                    n_err++;
                    $display("FAIL %s: actual=%h required=%h", c.name, act, c.exp);
                end
            end
        end
    end

    task automatic push_chk(input bit is_led, input logic [15:0] exp, input string name);
        chk_t c;
        c.is_led = is_led;
        c.exp    = exp;
        c.name   = name;
        q.push_back(c);
    endtask

    // Entered and left at 1ns after a falling edge
    task automatic step(input logic tms, input logic tdi);
        JB_TMS = tms;
        JB_TDI = tdi;
        @(posedge JB_TCK);
        @(negedge JB_TCK);
        #1;
    endtask

    // RTI -> full DR scan of n bits -> RTI (update applied on the way)
    task automatic scan_dr(input int n, input logic [31:0] din, input logic [31:0] dout,
                           input string name);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            push_chk(1'b0, {15'h0, dout[i]}, $sformatf("%s_b%0d", name, i));
            step(i == n - 1, din[i]);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    // RTI -> IR scan -> RTI; captured 0001 means TDO shows 1,0,0,0 for any opcode
    task automatic load_ir(input logic [3:0] op, input string name);
        logic [3:0] exp_tdo;
        exp_tdo = 4'b0001;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            push_chk(1'b0, {15'h0, exp_tdo[i]}, $sformatf("%s_ir_b%0d", name, i));
            step(i == 3, op[i]);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    initial begin
        JB_TRST = 1'b0;
        JB_TMS  = 1'b1;
        JB_TDI  = 1'b0;
        SW      = 16'h0000;
        @(negedge JB_TCK);
        #1;
        push_chk(1'b1, 16'h0000, "reset_led");
        push_chk(1'b0, 16'h0000, "reset_tdo");
        step(1'b1, 1'b0);
        JB_TRST = 1'b1;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        // IDCODE is the default instruction after reset
        scan_dr(32, 32'h0, ID, "idcode_rst");

        load_ir(4'b0100, "ld_idcode");
        scan_dr(32, 32'h0, ID, "idcode_ir");

        // Pause mid-scan, resume without recapture
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            push_chk(1'b0, {15'h0, ID[i]}, $sformatf("pause_b%0d", i));
            step(i == 7, 1'b0);
        end
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 8; i < 32; i++) begin
            push_chk(1'b0, {15'h0, ID[i]}, $sformatf("pause_b%0d", i));
            step(i == 31, 1'b0);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        // BYPASS: input 1,0,1,1 comes out 0,1,0,1
        load_ir(4'b1111, "ld_bypass");
        scan_dr(4, 32'hD, 32'hA, "bypass_f");
        load_ir(4'b0111, "ld_byp7");
        scan_dr(4, 32'hD, 32'hA, "bypass_7");

        SW = 16'hA5C3;
        load_ir(4'b0001, "ld_sample");
        scan_dr(16, 32'h0, 32'h0000_A5C3, "sample_sw");
        push_chk(1'b1, 16'h0000, "sample_led_unchanged");

        load_ir(4'b0010, "ld_wled");
        scan_dr(16, 32'h0000_BEEF, 32'h0, "wled1");
        push_chk(1'b1, 16'hBEEF, "wled1_led");
        scan_dr(16, 32'h0000_0F0F, 32'h0000_BEEF, "wled2");
        push_chk(1'b1, 16'h0F0F, "wled2_led");

        // Five TMS=1 edges from SH_DR reach TLR, which restores IDCODE
        load_ir(4'b0001, "ld_sample2");
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            push_chk(1'b0, {15'h0, SW[i]}, $sformatf("tlr_sw_b%0d", i));
            step(1'b0, 1'b0);
        end
        repeat (5) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        scan_dr(32, 32'h0, ID, "tlr_id");
        push_chk(1'b1, 16'h0F0F, "tlr_led_kept");

        // Asynchronous abort during a WRITE_LED shift
        load_ir(4'b0010, "ld_wled3");
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        push_chk(1'b0, 16'h0001, "pre_abort_tdo");
        push_chk(1'b1, 16'h0F0F, "pre_abort_led");
        step(1'b0, 1'b1);
        JB_TRST = 1'b0;
        push_chk(1'b1, 16'h0000, "abort_led");
        push_chk(1'b0, 16'h0000, "abort_tdo");
        step(1'b0, 1'b0);
        JB_TRST = 1'b1;
        step(1'b0, 1'b0);
        scan_dr(32, 32'h0, ID, "post_abort_id");
        push_chk(1'b1, 16'h0000, "post_abort_led");

        repeat (3) @(negedge JB_TCK);
        #3;
        if (q.size() != 0) begin
            n_err += q.size();
            $display("FAIL drain: actual=%0d pending required=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
